// File: rtl/bitdestreamer_if.sv
// Receive-side bundle for the FSK decoder: the sampled line plus the decoded frame and status strobes.
interface bitdestreamer_if #(
   parameter int DATALEN = 64
);
   logic               in;
   logic [DATALEN-1:0] dataout;
   logic               valid;
   logic               err;
   logic               busy;

   modport master (
      output in,
      input  dataout, valid, err, busy
   );

   modport slave (
      input  in,
      output dataout, valid, err, busy
   );
endinterface

// File: rtl/bitdestreamer.sv
// FSK pulse-width decoder: measures each low pulse of the line, maps it to a 0 or 1 bit,
// and assembles LSB-first frames of DATALEN bits with valid/err strobes.
module bitdestreamer #(
   parameter int DATALEN  = 64,
   parameter int CNTLEN   = 8,
   parameter int CLK_DIV1 = 16,
   parameter int CLK_DIV2 = 32,
   parameter int TOL      = 2
) (
   input  logic           clk,
   input  logic           rst,
   bitdestreamer_if.slave bus
);

   localparam int BCW = $clog2(DATALEN + 1);
   localparam logic [CNTLEN-1:0] CNT_MAX = '1;
   localparam logic [CNTLEN-1:0] ZERO_LO = CNTLEN'(CLK_DIV1 / 2 - TOL);
   localparam logic [CNTLEN-1:0] ZERO_HI = CNTLEN'(CLK_DIV1 / 2 + TOL);
   localparam logic [CNTLEN-1:0] ONE_LO  = CNTLEN'(CLK_DIV2 / 2 - TOL);
   localparam logic [CNTLEN-1:0] ONE_HI  = CNTLEN'(CLK_DIV2 / 2 + TOL);
   localparam logic [BCW-1:0]    LAST_BIT = BCW'(DATALEN - 1);

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         sync_q;
   logic [CNTLEN-1:0]  lcnt_q, lcnt_d;
   logic [CNTLEN-1:0]  hcnt_q, hcnt_d;
   logic [BCW-1:0]     bitcnt_q, bitcnt_d;
   logic [DATALEN-1:0] shreg_q, shreg_d;
   logic [DATALEN-1:0] dataout_q, dataout_d;
   logic               valid_q, valid_d;
   logic               err_q, err_d;

   logic               inS;
   logic               inD;
   logic               rise;
   logic               fall;
   logic               isZero;
   logic               isOne;
   logic [DATALEN-1:0] shifted;

   // sync_q[1] is the synchronized line, sync_q[2] its one-cycle-delayed copy for edge detection
   assign inS  = sync_q[1];
   assign inD  = sync_q[2];
   assign rise = inS & ~inD;
   assign fall = ~inS & inD;

   assign isZero  = (lcnt_q >= ZERO_LO) && (lcnt_q <= ZERO_HI);
   assign isOne   = (lcnt_q >= ONE_LO) && (lcnt_q <= ONE_HI);
   assign shifted = {isOne, shreg_q[DATALEN-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sync_q    <= '0;
         lcnt_q    <= '0;
         hcnt_q    <= '0;
         bitcnt_q  <= '0;
         shreg_q   <= '0;
         dataout_q <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= {sync_q[1:0], bus.in};
         lcnt_q    <= lcnt_d;
         hcnt_q    <= hcnt_d;
         bitcnt_q  <= bitcnt_d;
         shreg_q   <= shreg_d;
         dataout_q <= dataout_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lcnt_d    = lcnt_q;
      hcnt_d    = hcnt_q;
      bitcnt_d  = bitcnt_q;
      shreg_d   = shreg_q;
      dataout_d = dataout_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         IDLE: begin
            bitcnt_d = '0;
            hcnt_d   = '0;
            if (rise) begin
               state_d = HIGH;
            end
         end

         HIGH: begin
            if (fall) begin
               lcnt_d  = CNTLEN'(1);
               state_d = LOW;
            end else if (hcnt_q == CNT_MAX) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               hcnt_d = hcnt_q + CNTLEN'(1);
            end
         end

         LOW: begin
            // a rise closes the low pulse; its width decides the bit or aborts the frame
            if (rise) begin
               if (isZero || isOne) begin
                  shreg_d  = shifted;
                  bitcnt_d = bitcnt_q + BCW'(1);
                  if (bitcnt_q == LAST_BIT) begin
                     dataout_d = shifted;
                     valid_d   = 1'b1;
                     state_d   = IDLE;
                  end else begin
                     hcnt_d  = '0;
                     state_d = HIGH;
                  end
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end else if (lcnt_q > ONE_HI) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (!inS && (lcnt_q != CNT_MAX)) begin
               lcnt_d = lcnt_q + CNTLEN'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.dataout = dataout_q;
   assign bus.valid   = valid_q;
   assign bus.err     = err_q;
   assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_bitdestreamer.sv
// Scoreboard bench for bitdestreamer with DATALEN=8: directed frames push expected events,
// a monitor pops and compares on every valid/err strobe.
module tb_bitdestreamer;

   localparam int DL = 8;

   typedef struct packed {
      logic          isErr;
      logic [DL-1:0] data;
   } expEvent_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   expEvent_t expQ[$];

   bitdestreamer_if #(.DATALEN(DL)) bus ();

   bitdestreamer #(
      .DATALEN (DL),
      .CNTLEN  (8),
      .CLK_DIV1(16),
      .CLK_DIV2(32),
      .TOL     (2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // line driven at falling edges so each level covers exactly n rising edges
   task automatic applyStimulus(input logic level, input int n);
      bus.in = level;
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic sendBit(input int hw, input int lw);
      applyStimulus(1'b1, hw);
      applyStimulus(1'b0, lw);
   endtask

   task automatic sendFrame(input logic [DL-1:0] d, input int hw, input int gap);
      expQ.push_back('{isErr: 1'b0, data: d});
      for (int i = 0; i < DL; i++) begin
         sendBit(hw, d[i] ? 16 : 8);
      end
      applyStimulus(1'b1, 5);
      applyStimulus(1'b0, gap);
   endtask

   task automatic expectErr();
      expQ.push_back('{isErr: 1'b1, data: '0});
   endtask

   // monitor: every strobe must match the oldest outstanding expectation
   always @(negedge clk) begin
      expEvent_t ev;
      if (!rst && (bus.valid || bus.err)) begin
         total++;
         if (bus.valid && bus.err) begin
            bad++;
            $display("[TB] FAIL strobes: valid=1 err=1, expected only one");
            if (expQ.size() != 0) ev = expQ.pop_front();
         end else if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected: valid=%0b err=%0b dataout=%0h, expected no event",
                     bus.valid, bus.err, bus.dataout);
         end else begin
            ev = expQ.pop_front();
            if (ev.isErr != bus.err || (!ev.isErr && bus.dataout != ev.data)) begin
               bad++;
               $display("[TB] FAIL event: err=%0b dataout=%0h, expected err=%0b dataout=%0h",
                        bus.err, bus.dataout, ev.isErr, ev.data);
            end
         end
      end
   end

   initial begin
      int errLows[4];
      total   = 0;
      bad     = 0;
      bus.in  = 1'b0;
      rst     = 1'b1;
      errLows = '{5, 11, 13, 19};

      repeat (3) @(negedge clk);
      checkOutput("reset dataout", 64'(bus.dataout), 64'h0);
      checkOutput("reset valid", 64'(bus.valid), 64'h0);
      checkOutput("reset err", 64'(bus.err), 64'h0);
      checkOutput("reset busy", 64'(bus.busy), 64'h0);
      rst = 1'b0;
      applyStimulus(1'b0, 5);

      $display("[TB] frame 0xA5 with exact widths");
      sendFrame(8'hA5, 5, 20);
      checkOutput("A5 hold", 64'(bus.dataout), 64'hA5);

      $display("[TB] tolerance edges accepted");
      expQ.push_back('{isErr: 1'b0, data: 8'hAC});
      sendBit(5, 6);
      sendBit(5, 10);
      sendBit(5, 14);
      sendBit(5, 18);
      sendBit(5, 8);
      sendBit(5, 16);
      sendBit(5, 6);
      sendBit(5, 18);
      applyStimulus(1'b1, 5);
      applyStimulus(1'b0, 20);
      checkOutput("AC hold", 64'(bus.dataout), 64'hAC);

      $display("[TB] tolerance edges rejected");
      for (int i = 0; i < 4; i++) begin
         expectErr();
         sendBit(5, errLows[i]);
         applyStimulus(1'b1, 5);
         applyStimulus(1'b0, 10);
         checkOutput($sformatf("busy after low %0d", errLows[i]), 64'(bus.busy), 64'h0);
      end
      checkOutput("dataout kept after err", 64'(bus.dataout), 64'hAC);

      $display("[TB] back-to-back frames");
      sendFrame(8'hFF, 5, 1);
      sendFrame(8'h00, 5, 20);

      $display("[TB] truncated frame then 0x3C");
      expectErr();
      sendBit(5, 8);
      sendBit(5, 16);
      sendBit(5, 8);
      applyStimulus(1'b1, 5);
      applyStimulus(1'b0, 40);
      checkOutput("busy after truncation", 64'(bus.busy), 64'h0);
      sendFrame(8'h3C, 5, 20);
      checkOutput("3C hold", 64'(bus.dataout), 64'h3C);

      $display("[TB] reset mid-frame then 0x81");
      sendBit(5, 16);
      sendBit(5, 8);
      sendBit(5, 8);
      sendBit(5, 16);
      applyStimulus(1'b1, 5);
      applyStimulus(1'b0, 4);
      checkOutput("busy before reset", 64'(bus.busy), 64'h1);
      rst = 1'b1;
      #1;
      checkOutput("reset dataout mid-frame", 64'(bus.dataout), 64'h0);
      checkOutput("reset busy mid-frame", 64'(bus.busy), 64'h0);
      checkOutput("reset valid mid-frame", 64'(bus.valid), 64'h0);
      checkOutput("reset err mid-frame", 64'(bus.err), 64'h0);
      @(negedge clk);
      applyStimulus(1'b0, 3);
      rst = 1'b0;
      applyStimulus(1'b0, 5);
      sendFrame(8'h81, 5, 20);

      $display("[TB] long phase delay and stuck-high line");
      sendFrame(8'h5A, 200, 20);
      checkOutput("5A hold", 64'(bus.dataout), 64'h5A);
      expectErr();
      applyStimulus(1'b1, 300);
      applyStimulus(1'b0, 10);
      checkOutput("busy after stuck high", 64'(bus.busy), 64'h0);

      applyStimulus(1'b0, 20);
      checkOutput("pending expectations", 64'(expQ.size()), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
